rnd_harvester: RTL and testbench

RND_HARVESTER -- requirements
Module: rnd_harvester

---
 rtl/rnd_harvester.sv | 154 +++++++++++++++
 tb/tb_rnd_harvester.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_harvester.sv
// Entropy harvester: synchronizes a raw random bit, samples it periodically,
// debiases pairs with a Von Neumann extractor and packs the result into a byte FIFO.
module rnd_harvester #(
    parameter int SAMPLE_DIV = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          raw_bit,
    input  logic                          en,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } vn_state_t;

    logic             sync_meta;
    logic             sync_bit;
    logic [7:0]       sample_cnt;
    logic             strobe;
    vn_state_t        state;
    logic             first;
    logic             emit;
    logic [7:0]       pack_reg;
    logic [2:0]       bit_cnt;
    logic             push;
    logic [7:0]       push_byte;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [LVL_W-1:0] level_after_pop;
    logic [LVL_W-1:0] level_next;
    logic [7:0]       head_next;

    // raw_bit is asynchronous to clk, so it only enters through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_bit  <= 1'b0;
        end else begin
            sync_meta <= raw_bit;
            sync_bit  <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= 8'd0;
        end else if (!en) begin
            sample_cnt <= 8'd0;
        end else if (sample_cnt == 8'(SAMPLE_DIV - 1)) begin
            sample_cnt <= 8'd0;
        end else begin
            sample_cnt <= sample_cnt + 8'd1;
        end
    end

    assign strobe = en && (sample_cnt == 8'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            first <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
        end else if (strobe) begin
            case (state)
                IDLE: begin
                    first <= sync_bit;
                    state <= HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A differing pair yields its first sample; equal pairs yield nothing
    assign emit      = strobe && (state == HAVE_FIRST) && (sync_bit != first);
    assign push      = emit && (bit_cnt == 3'd7);
    assign push_byte = {first, pack_reg[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg <= 8'h00;
            bit_cnt  <= 3'd0;
        end else if (emit) begin
            pack_reg <= push_byte;
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    always_comb begin
        pop             = out_valid && out_ready;
        full            = (fifo_level == LVL_W'(FIFO_DEPTH));
        wr_en           = push && (!full || pop);
        drop            = push && full && !pop;
        level_after_pop = fifo_level - LVL_W'(pop);
        level_next      = level_after_pop + LVL_W'(wr_en);
        rd_next         = rd_ptr + PTR_W'(pop);
        // When the FIFO drains to nothing this edge, the incoming byte becomes the head
        head_next       = (level_after_pop == '0) ? push_byte : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(wr_en);
            rd_ptr     <= rd_next;
            fifo_level <= level_next;
            out_valid  <= (level_next != '0);
            if (level_next != '0) begin
                out_data <= head_next;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rnd_harvester.sv
// Testbench for rnd_harvester: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_rnd_harvester;

    localparam int SAMPLE_DIV = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             raw_bit = 1'b0;
    logic             en = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit         m_s1, m_s2, m_have, m_first, m_ovf;
    int         m_run;
    bit         m_bits[$];
    logic [7:0] m_q[$];

    rnd_harvester #(.SAMPLE_DIV(SAMPLE_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .en(en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_have = 0; m_first = 0; m_ovf = 0; m_run = 0;
        m_bits.delete();
        m_q.delete();
    endtask

    task automatic model_step();
        bit pop, stb, emitted, ebit, drop;
        logic [7:0] b;
        pop = (m_q.size() != 0) && out_ready;
        stb = 0; emitted = 0; ebit = 0; drop = 0;
        if (en) begin
            stb = ((m_run % SAMPLE_DIV) == SAMPLE_DIV - 1);
            m_run++;
        end else begin
            m_run = 0;
            m_have = 0;
        end
        if (stb) begin
            if (!m_have) begin
                m_have = 1; m_first = m_s2;
            end else begin
                m_have = 0;
                if (m_s2 != m_first) begin emitted = 1; ebit = m_first; end
            end
        end
        if (pop) b = m_q.pop_front();
        if (emitted) begin
            m_bits.push_back(ebit);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) b[i] = m_bits[i];
                m_bits.delete();
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(b);
                else drop = 1;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        m_s2 = m_s1;
        m_s1 = raw_bit;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic strobe(input bit b, input bit pop_at_edge);
        en = 1'b1;
        raw_bit = b;
        repeat (SAMPLE_DIV - 1) tick();
        out_ready = pop_at_edge;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            strobe(v[i], 1'b0);
            strobe(!v[i], 1'b0);
        end
    endtask

    task automatic pop_one();
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_level !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: valid=%b data=%h level=%0d ovf=%b, required 0 00 0 0",
                     out_valid, out_data, fifo_level, overflow);
        end
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: valid=%b level=%0d ovf=%b, required 0 0 0",
                     out_valid, fifo_level, overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ff_byte();
        for (int i = 0; i < 7; i++) begin
            strobe(1'b1, 1'b0);
            strobe(1'b0, 1'b0);
        end
        strobe(1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ff_early_valid: got %b required 0", out_valid);
        end
        strobe(1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || fifo_level !== LVL_W'(1)) begin
            n_err++;
            $display("FAIL ff_byte: valid=%b data=%h level=%0d, required 1 ff 1",
                     out_valid, out_data, fifo_level);
        end
        pop_one();
        n_vec++;
        if (out_valid !== 1'b0 || fifo_level !== '0) begin
            n_err++;
            $display("FAIL ff_pop: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
        end
    endtask

    task automatic test_zero_and_equal();
        for (int i = 0; i < 8; i++) begin
            strobe(i[0], 1'b0);
            strobe(i[0], 1'b0);
        end
        n_vec++;
        if (fifo_level !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL equal_pairs: level=%0d valid=%b, required 0 0", fifo_level, out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            strobe(1'b0, 1'b0);
            strobe(1'b1, 1'b0);
            strobe(!i[0], 1'b0);
            strobe(!i[0], 1'b0);
        end
        n_vec++;
        if (out_data !== 8'h00 || fifo_level !== LVL_W'(1)) begin
            n_err++;
            $display("FAIL zero_byte: data=%h level=%0d, required 00 1", out_data, fifo_level);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [5];
        bytes = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h55};
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        n_vec++;
        if (fifo_level !== LVL_W'(4) || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_no_ovf: level=%0d ovf=%b, required 4 0", fifo_level, overflow);
        end
        send_byte(bytes[4]);
        n_vec++;
        if (fifo_level !== LVL_W'(4) || overflow !== 1'b1 || out_data !== 8'hA5) begin
            n_err++;
            $display("FAIL overflow_drop: level=%0d ovf=%b data=%h, required 4 1 a5",
                     fifo_level, overflow, out_data);
        end
        clr_ovf = 1'b1;
        en = 1'b0;
        tick();
        clr_ovf = 1'b0;
        n_vec++;
        if (overflow !== 1'b0 || fifo_level !== LVL_W'(4)) begin
            n_err++;
            $display("FAIL clr_ovf: ovf=%b level=%0d, required 0 4", overflow, fifo_level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] expq [4];
        logic [7:0] v;
        expq = '{8'h3C, 8'h81, 8'h7E, 8'h55};
        v = 8'h55;
        for (int i = 0; i < 7; i++) begin
            strobe(v[i], 1'b0);
            strobe(!v[i], 1'b0);
        end
        strobe(v[7], 1'b0);
        strobe(!v[7], 1'b1);
        n_vec++;
        if (fifo_level !== LVL_W'(4) || overflow !== 1'b0 || out_data !== 8'h3C) begin
            n_err++;
            $display("FAIL full_push_pop: level=%0d ovf=%b data=%h, required 4 0 3c",
                     fifo_level, overflow, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_data !== expq[i] || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL drain_order[%0d]: data=%h valid=%b, required %h 1",
                         i, out_data, out_valid, expq[i]);
            end
            pop_one();
        end
        n_vec++;
        if (fifo_level !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty: level=%0d valid=%b, required 0 0", fifo_level, out_valid);
        end
    endtask

    task automatic test_en_drop();
        bit rest [7];
        rest = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            strobe(rest[i], 1'b0);
            strobe(!rest[i], 1'b0);
        end
        n_vec++;
        if (fifo_level !== LVL_W'(1) || out_data !== 8'h4D) begin
            n_err++;
            $display("FAIL en_drop: level=%0d data=%h, required 1 4d", fifo_level, out_data);
        end
        pop_one();
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        send_byte(8'h12);
        send_byte(8'h34);
        v = 8'h0D;
        for (int i = 0; i < 5; i++) begin
            strobe(v[i], 1'b0);
            strobe(!v[i], 1'b0);
        end
        strobe(1'b1, 1'b0);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (fifo_level !== '0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: level=%0d valid=%b data=%h, required 0 0 00",
                     fifo_level, out_valid, out_data);
        end
        tick();
        rst_n = 1'b1;
        v = 8'hC3;
        for (int i = 0; i < 7; i++) begin
            strobe(v[i], 1'b0);
            strobe(!v[i], 1'b0);
        end
        n_vec++;
        if (fifo_level !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_partial: level=%0d valid=%b, required 0 0", fifo_level, out_valid);
        end
        strobe(v[7], 1'b0);
        strobe(!v[7], 1'b0);
        n_vec++;
        if (fifo_level !== LVL_W'(1) || out_data !== 8'hC3) begin
            n_err++;
            $display("FAIL post_reset_byte: level=%0d data=%h, required 1 c3", fifo_level, out_data);
        end
        pop_one();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4800; c++) begin
            raw_bit   = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 15) != 0);
            out_ready = ((c / 800) % 2 == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
            clr_ovf   = ($urandom_range(0, 63) == 0);
            tick();
            n_vec++;
            if (fifo_level !== LVL_W'(m_q.size()) || out_valid !== (m_q.size() != 0)
                || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rand_ctrl@%0d: level=%0d valid=%b ovf=%b, required %0d %b %b",
                         c, fifo_level, out_valid, overflow, m_q.size(), m_q.size() != 0, m_ovf);
            end
            if (m_q.size() != 0) begin
                n_vec++;
                if (out_data !== m_q[0]) begin
                    n_err++;
                    $display("FAIL rand_data@%0d: got %h required %h", c, out_data, m_q[0]);
                end
            end
        end
        en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ff_byte();
        test_zero_and_equal();
        test_overflow();
        test_full_push_pop();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
